// File: rtl/buck_cfg_shadow.sv
// Purpose: shadow SPI config regs, range-check on commit, apply glitch-free to PWM core at period boundary.
// Latency: commit edge to active outputs 4 cycles when disabled; 2 cycles after the boundary when enabled.
// Backpressure: none; a new commit while busy restarts with the latest config. Optional CFG_RAMP_EN slews vref.
module buck_cfg_shadow #(
    parameter int DATA_BITS  = 16,
    parameter int MAX_PHASES = 4,
    parameter int MIN_PERIOD = 16,
    parameter int DEF_PERIOD = 100,
    parameter int RAMP_STEP  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] reg0,
    input  logic [DATA_BITS-1:0] reg1,
    input  logic [DATA_BITS-1:0] reg2,
    input  logic [DATA_BITS-1:0] reg3,
    input  logic [DATA_BITS-1:0] reg4,
    input  logic [DATA_BITS-1:0] reg5,
    input  logic                 period_start,
    output logic [DATA_BITS-1:0] pwm_period,
    output logic [DATA_BITS-1:0] duty_max,
    output logic [DATA_BITS-1:0] deadtime,
    output logic [2:0]           phase_cnt,
    output logic                 pwm_en,
    output logic [DATA_BITS-1:0] vref,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 cfg_applied,
    output logic [7:0]           rej_cnt
);

    typedef enum logic [1:0] {IDLE, CHECK, WAIT_BND, APPLY} state_t;

    localparam logic [DATA_BITS-1:0] MIN_PER  = DATA_BITS'(MIN_PERIOD);
    localparam logic [DATA_BITS-1:0] DEF_PER  = DATA_BITS'(DEF_PERIOD);
    localparam logic [DATA_BITS-1:0] RAMP_INC = DATA_BITS'(RAMP_STEP);
    localparam logic [2:0]           MAX_PH   = 3'(MAX_PHASES);

    state_t state, state_nxt;

    logic                 req_q;
    logic                 late_q;
    logic                 commit;
    logic                 cap_en;
    logic                 do_rej;
    logic                 do_apply;
    logic                 legal;

    logic [DATA_BITS-1:0] stg_period;
    logic [DATA_BITS-1:0] stg_duty;
    logic [DATA_BITS-1:0] stg_dt;
    logic [2:0]           stg_ph;
    logic                 stg_en;
    logic [DATA_BITS-1:0] stg_vref;

    // Only reg5[0], reg3[15] and reg3[2:0] carry meaning; ramp step matters only with ramping.
    logic unused_bits;
`ifdef CFG_RAMP_EN
    assign unused_bits = ^{reg5[DATA_BITS-1:1], reg3[DATA_BITS-2:3]};
`else
    assign unused_bits = ^{reg5[DATA_BITS-1:1], reg3[DATA_BITS-2:3], RAMP_INC};
`endif

    assign commit = reg5[0] & ~req_q;
    assign busy   = (state != IDLE);

    // Deadtime is compared at two extra bits so 4*deadtime cannot wrap.
    assign legal = (stg_period >= MIN_PER) &&
                   (stg_duty < stg_period) &&
                   ({stg_dt, 2'b00} < {2'b00, stg_period}) &&
                   (stg_ph != 3'd0) && (stg_ph <= MAX_PH);

    // State register plus commit edge detector and the commit-during-APPLY holdover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            late_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            req_q  <= reg5[0];
            late_q <= (state == APPLY) && commit;
        end
    end

    // Next state: any commit outside APPLY restarts the check with fresh staging.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (commit || late_q) state_nxt = CHECK;
            CHECK:    if (commit) state_nxt = CHECK;
                      else if (legal) state_nxt = WAIT_BND;
                      else state_nxt = IDLE;
            WAIT_BND: if (commit) state_nxt = CHECK;
                      else if (!pwm_en || period_start) state_nxt = APPLY;
            APPLY:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Per-state actions: snapshot, reject, apply.
    always_comb begin
        cap_en   = 1'b0;
        do_rej   = 1'b0;
        do_apply = 1'b0;
        case (state)
            IDLE:     cap_en = commit || late_q;
            CHECK:    begin
                          cap_en = commit;
                          do_rej = !commit && !legal;
                      end
            WAIT_BND: cap_en = commit;
            APPLY:    do_apply = 1'b1;
            default:  ;
        endcase
    end

    // Staging snapshot of reg0..reg4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_period <= '0;
            stg_duty   <= '0;
            stg_dt     <= '0;
            stg_ph     <= '0;
            stg_en     <= 1'b0;
            stg_vref   <= '0;
        end else if (cap_en) begin
            stg_period <= reg0;
            stg_duty   <= reg1;
            stg_dt     <= reg2;
            stg_ph     <= reg3[2:0];
            stg_en     <= reg3[DATA_BITS-1];
            stg_vref   <= reg4;
        end
    end

    // Active config, error flag, reject counter and applied pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_period  <= DEF_PER;
            duty_max    <= '0;
            deadtime    <= '0;
            phase_cnt   <= 3'd1;
            pwm_en      <= 1'b0;
            cfg_err     <= 1'b0;
            cfg_applied <= 1'b0;
            rej_cnt     <= '0;
        end else begin
            cfg_applied <= do_apply;
            if (do_apply) begin
                pwm_period <= stg_period;
                duty_max   <= stg_duty;
                deadtime   <= stg_dt;
                phase_cnt  <= stg_ph;
                pwm_en     <= stg_en;
                cfg_err    <= 1'b0;
            end
            if (do_rej) begin
                cfg_err <= 1'b1;
                if (rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
            end
        end
    end

`ifdef CFG_RAMP_EN
    logic [DATA_BITS-1:0] vref_tgt;

    // Target loads on apply; vref tracks it directly when disabled, else slews once per period without overshoot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vref_tgt <= '0;
            vref     <= '0;
        end else begin
            if (do_apply) vref_tgt <= stg_vref;
            if (!pwm_en) begin
                vref <= vref_tgt;
            end else if (period_start) begin
                if (vref < vref_tgt)
                    vref <= ((vref_tgt - vref) > RAMP_INC) ? vref + RAMP_INC : vref_tgt;
                else if (vref > vref_tgt)
                    vref <= ((vref - vref_tgt) > RAMP_INC) ? vref - RAMP_INC : vref_tgt;
            end
        end
    end
`else
    // vref is applied together with the rest of the config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           vref <= '0;
        else if (do_apply) vref <= stg_vref;
    end
`endif

endmodule

// File: tb/tb_buck_cfg_shadow.sv
module tb_buck_cfg_shadow;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5;
    logic        period_start;
    logic [15:0] pwm_period, duty_max, deadtime, vref;
    logic [2:0]  phase_cnt;
    logic        pwm_en, busy, cfg_err, cfg_applied;
    logic [7:0]  rej_cnt;

    always #5 clk = ~clk;

    buck_cfg_shadow dut (
        .clk(clk), .rst(rst),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5),
        .period_start(period_start),
        .pwm_period(pwm_period), .duty_max(duty_max), .deadtime(deadtime),
        .phase_cnt(phase_cnt), .pwm_en(pwm_en), .vref(vref),
        .busy(busy), .cfg_err(cfg_err), .cfg_applied(cfg_applied), .rej_cnt(rej_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a pending job with timestamps, not a state machine.
    typedef struct {
        int period; int duty; int dt; int ph; int en; int vref;
    } cfg_t;

    cfg_t m_act, m_job;
    int   m_vtgt;
    bit   m_err, m_applied, m_live, m_prev, m_late;
    int   m_rej, m_tcap, m_apply_at, cyc_n;

    function automatic cfg_t snap();
        cfg_t c;
        c.period = int'(reg0);
        c.duty   = int'(reg1);
        c.dt     = int'(reg2);
        c.ph     = int'(reg3[2:0]);
        c.en     = int'(reg3[15]);
        c.vref   = int'(reg4);
        return c;
    endfunction

    function automatic bit is_legal(cfg_t c);
        return (c.period >= 16) && (c.duty < c.period) && (4 * c.dt < c.period) &&
               (c.ph >= 1) && (c.ph <= 4);
    endfunction

    task automatic model_reset();
        m_act = '{period: 100, duty: 0, dt: 0, ph: 1, en: 0, vref: 0};
        m_job = '{period: 0, duty: 0, dt: 0, ph: 0, en: 0, vref: 0};
        m_vtgt = 0; m_err = 0; m_applied = 0; m_live = 0; m_prev = 0; m_late = 0;
        m_rej = 0; m_tcap = -10; m_apply_at = -1;
    endtask

    task automatic model_step();
        bit commit;
        int n;
        n = cyc_n;
        commit = reg5[0] && !m_prev;
        m_prev = reg5[0];
        m_applied = 0;
`ifdef CFG_RAMP_EN
        if (m_act.en == 0) m_act.vref = m_vtgt;
        else if (period_start) begin
            if (m_act.vref < m_vtgt)
                m_act.vref = (m_vtgt - m_act.vref > 8) ? m_act.vref + 8 : m_vtgt;
            else if (m_act.vref > m_vtgt)
                m_act.vref = (m_act.vref - m_vtgt > 8) ? m_act.vref - 8 : m_vtgt;
        end
`endif
        if (m_live && m_apply_at == n) begin
            int keep_vref;
            keep_vref = m_act.vref;
            m_act = m_job;
`ifdef CFG_RAMP_EN
            m_vtgt = m_job.vref;
            m_act.vref = keep_vref;
`endif
            m_err = 0; m_applied = 1; m_live = 0; m_apply_at = -1;
            m_late = commit;
        end else if (commit || m_late) begin
            m_job = snap(); m_live = 1; m_tcap = n; m_apply_at = -1; m_late = 0;
        end else if (m_live && n == m_tcap + 1) begin
            if (!is_legal(m_job)) begin
                m_err = 1; m_live = 0;
                if (m_rej < 255) m_rej++;
            end
        end else if (m_live && m_apply_at < 0 && n >= m_tcap + 2) begin
            if (m_act.en == 0 || period_start) m_apply_at = n + 1;
        end
        cyc_n++;
    endtask

    task automatic compare_all();
        checks++;
        if (int'(pwm_period) != m_act.period || int'(duty_max) != m_act.duty ||
            int'(deadtime) != m_act.dt || int'(phase_cnt) != m_act.ph ||
            int'(pwm_en) != m_act.en || int'(vref) != m_act.vref ||
            busy != m_live || cfg_err != m_err || cfg_applied != m_applied ||
            int'(rej_cnt) != m_rej) begin
            failures++;
            $display("FAIL cycle_cmp n=%0d got per=%0d duty=%0d dt=%0d ph=%0d en=%0d vref=%0d busy=%0d err=%0d app=%0d rej=%0d want per=%0d duty=%0d dt=%0d ph=%0d en=%0d vref=%0d busy=%0d err=%0d app=%0d rej=%0d",
                     cyc_n, pwm_period, duty_max, deadtime, phase_cnt, pwm_en, vref, busy, cfg_err,
                     cfg_applied, rej_cnt, m_act.period, m_act.duty, m_act.dt, m_act.ph, m_act.en,
                     m_act.vref, m_live, m_err, m_applied, m_rej);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (rst) model_reset();
        compare_all();
        if (!rst) model_step();
        else cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic commit_pulse();
        reg5 = 16'h0001; cyc(); reg5 = 16'h0000;
    endtask

    initial begin
        cyc_n = 0;
        rst = 1; reg0 = 0; reg1 = 0; reg2 = 0; reg3 = 0; reg4 = 0; reg5 = 0; period_start = 0;
        model_reset();
        cyc(); cyc();
        rst = 0;
        cyc(); cyc();
        chk("rst_period", int'(pwm_period), 100);
        chk("rst_duty", int'(duty_max), 0);
        chk("rst_phase", int'(phase_cnt), 1);
        chk("rst_en", int'(pwm_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rej", int'(rej_cnt), 0);

        // Disabled commit: visible 4 cycles after the edge.
        reg0 = 200; reg1 = 150; reg2 = 10; reg3 = 16'h8002; reg4 = 500;
        commit_pulse(); cyc(); cyc(); cyc();
        chk("dis_period", int'(pwm_period), 200);
        chk("dis_phase", int'(phase_cnt), 2);
        chk("dis_en", int'(pwm_en), 1);
        chk("dis_applied", int'(cfg_applied), 1);
        cyc();
        chk("dis_applied_end", int'(cfg_applied), 0);

        // Enabled commit waits for the period boundary.
        reg0 = 300;
        commit_pulse(); repeat (5) cyc();
        chk("en_busy", int'(busy), 1);
        chk("en_hold", int'(pwm_period), 200);
        period_start = 1; cyc(); period_start = 0;
        chk("en_hold2", int'(pwm_period), 200);
        cyc();
        chk("en_period", int'(pwm_period), 300);
        chk("en_applied", int'(cfg_applied), 1);

        // Rejects: deadtime too large, then zero phases.
        reg0 = 200; reg2 = 50;
        commit_pulse(); cyc(); cyc();
        chk("rej1_err", int'(cfg_err), 1);
        chk("rej1_cnt", int'(rej_cnt), 1);
        chk("rej1_keep", int'(pwm_period), 300);
        chk("rej1_busy", int'(busy), 0);
        reg2 = 10; reg3 = 16'h8000;
        commit_pulse(); cyc(); cyc();
        chk("rej2_cnt", int'(rej_cnt), 2);
        chk("rej2_err", int'(cfg_err), 1);
        reg3 = 16'h8002; reg0 = 250;
        commit_pulse(); cyc(); cyc();
        period_start = 1; cyc(); period_start = 0; cyc();
        chk("legal_period", int'(pwm_period), 250);
        chk("legal_err_clr", int'(cfg_err), 0);

        // Restart in WAIT_BND: latest config wins.
        reg0 = 350;
        commit_pulse(); cyc();
        reg0 = 400;
        commit_pulse(); cyc();
        period_start = 1; cyc(); period_start = 0; cyc();
        chk("restart_period", int'(pwm_period), 400);

        // Reset while waiting for a boundary.
        reg0 = 500;
        commit_pulse(); cyc(); cyc();
        rst = 1; #1;
        chk("arst_period", int'(pwm_period), 100);
        chk("arst_busy", int'(busy), 0);
        cyc(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("arst_no_applied", int'(cfg_applied), 0);
        end
        chk("arst_period_hold", int'(pwm_period), 100);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int per;
            per = $urandom_range(8, 400);
            reg0 = 16'(per);
            reg1 = 16'($urandom_range(0, per + 5));
            reg2 = 16'($urandom_range(0, per / 4 + 2));
            reg3 = {1'($urandom_range(0, 1)), 12'($urandom), 3'($urandom_range(0, 5))};
            reg4 = 16'($urandom);
            reg5 = {15'($urandom), ($urandom_range(0, 4) == 0) ? ~reg5[0] : reg5[0]};
            period_start = ($urandom_range(0, 6) == 0);
            rst = ($urandom_range(0, 599) == 0);
            cyc();
        end
        rst = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
